axi_lite_gp_bridge: RTL and testbench
=====================================

AXI_LITE_GP_BRIDGE -- requirements
Module: axi_lite_gp_bridge

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI/GP data width (32 or 64).
REQ-002 SHALL have parameter GP_ADDR_WIDTH, default 6, GP word-address width.
REQ-003 SHALL have parameter C_S_AXI_ADDR_WIDTH, default GP_ADDR_WIDTH+log2(C_S_AXI_DATA_WIDTH/8), AXI byte-address width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16, GP wait limit in cycles (>=2).
REQ-005 SHALL have ports, clock and reset first:
- s_axi_aclk  in  1  sole clock.
- s_axi_aresetn  in  1  asynchronous, active-low reset.
- s_axi_aw{addr,prot,valid,ready}, s_axi_w{data,strb,valid,ready}, s_axi_b{resp,valid,ready}  AXI4-Lite write channels, widths per parameters.
- s_axi_ar{addr,prot,valid,ready}, s_axi_r{data,resp,valid,ready}  AXI4-Lite read channels.
- write  out  1  GP write request; write_addrs  out  GP_ADDR_WIDTH; write_data  out  DATA; write_strobe  out  DATA/8.
- write_done  in  1; write_error  in  1.
- read  out  1  GP read request; read_addrs  out  GP_ADDR_WIDTH; read_data  in  DATA; read_done  in  1; read_error  in  1.

Function
REQ-006 Write and read paths SHALL be independent FSMs; simultaneous activity on both SHALL not interact.
REQ-007 Write FSM states SHALL be W_IDLE, W_GP, W_RESP.
REQ-008 In W_IDLE, awready SHALL be 1 until an address is captured and wready 1 until data is captured; AW and W may handshake in the same or different cycles, in either order.
REQ-009 When both are captured, next cycle SHALL enter W_GP with write=1, write_addrs=awaddr[C_S_AXI_ADDR_WIDTH-1:log2(DATA/8)], write_data=wdata, write_strobe=wstrb; awready=wready=0.
REQ-010 In W_GP, write_done=1 at a rising edge SHALL drop write, set bvalid=1, bresp=write_error?2'b10:2'b00, enter W_RESP; write_done already high on entry completes in one cycle.
REQ-011 In W_RESP, bvalid/bresp SHALL hold until bready=1 at an edge, then return to W_IDLE (awready/wready=1 next cycle).
REQ-012 Read FSM states SHALL be R_IDLE, R_GP, R_RESP; arready=1 only in R_IDLE; AR handshake SHALL enter R_GP with read=1, read_addrs from araddr as REQ-009.
REQ-013 In R_GP, read_done=1 SHALL capture read_data into rdata, set rresp=read_error?2'b10:2'b00, rvalid=1, drop read.
REQ-014 rdata/rresp SHALL stay stable while rvalid=1 regardless of read_data changes; rready=1 completes and returns to R_IDLE.
REQ-015 Write/read GP outputs SHALL stay stable for the whole W_GP/R_GP period even if AXI inputs change.
REQ-016 awprot/arprot SHALL be ignored.

Reset
REQ-017 s_axi_aresetn=0 SHALL immediately force both FSMs to idle, all valid/request outputs 0, data/address/resp outputs 0, timeout counters 0.
REQ-018 Reset mid-transaction SHALL abandon it without response; after release, awready=wready=arready=1 at the first edge.

Configuration
REQ-019 Macro AXI_GP_TIMEOUT_EN defined: a per-path counter SHALL count cycles in W_GP/R_GP; if done is not seen within TIMEOUT_CYCLES cycles, request SHALL drop and response SHALL be issued with resp=2'b10 (rdata=0); done and timeout in the same cycle SHALL be treated as done.
REQ-020 AXI_GP_TIMEOUT_EN undefined: no counter; W_GP/R_GP SHALL wait indefinitely; TIMEOUT_CYCLES unused.

Verification
REQ-021 done=1, bready=rready=1, AW+W+AR same cycle, wdata=0x12345678, read_data=0xBABA1195 -> write/read high 1 cycle, bresp=0, rdata=0xBABA1195, rresp=0.
REQ-022 AW two cycles before W, write_done delayed 2 cycles -> write high exactly 3 cycles, write_data=W value, single bvalid.
REQ-023 rready=0 for 3 cycles after rvalid, read_data changed to 0 -> rdata stays 0xDEADBEEF until rready handshake; arready=0 meanwhile.
REQ-024 write_error=1, read_error=1 with done -> bresp=2'b10, rresp=2'b10.
REQ-025 AXI_GP_TIMEOUT_EN, TIMEOUT_CYCLES=16, done never asserted -> request drops after 16 cycles, resp=2'b10, rdata=0; without macro, request stays high.
REQ-026 Reset asserted during W_GP -> write=0, bvalid=0 immediately; next transaction completes normally.

Source files
------------

// File: rtl/axi_lite_gp_bridge.sv
// AXI4-Lite slave to general-purpose (GP) register bus bridge, independent write/read FSMs.
// Optional GP wait limit: define AXI_GP_TIMEOUT_EN (limit given by TIMEOUT_CYCLES).
module axi_lite_gp_bridge #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int GP_ADDR_WIDTH      = 6,
    parameter int C_S_AXI_ADDR_WIDTH = GP_ADDR_WIDTH + $clog2(C_S_AXI_DATA_WIDTH/8),
    parameter int TIMEOUT_CYCLES     = 16
) (
    input  logic                            s_axi_aclk,
    input  logic                            s_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic                            write,
    output logic [GP_ADDR_WIDTH-1:0]        write_addrs,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   write_data,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0] write_strobe,
    input  logic                            write_done,
    input  logic                            write_error,
    output logic                            read,
    output logic [GP_ADDR_WIDTH-1:0]        read_addrs,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   read_data,
    input  logic                            read_done,
    input  logic                            read_error
);
    localparam int LSB = $clog2(C_S_AXI_DATA_WIDTH/8);
    localparam int DW  = C_S_AXI_DATA_WIDTH;
    localparam int SW  = C_S_AXI_DATA_WIDTH/8;

    typedef enum logic [1:0] {W_IDLE, W_GP, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_GP, R_RESP} rstate_t;

    wstate_t                  r_wst;
    rstate_t                  r_rst;
    logic                     r_awready, r_wready, r_aw_got, r_w_got;
    logic                     r_write, r_bvalid, r_read, r_rvalid, r_arready;
    logic [1:0]               r_bresp, r_rresp;
    logic [GP_ADDR_WIDTH-1:0] r_waddr, r_raddr;
    logic [DW-1:0]            r_wdata, r_rdata;
    logic [SW-1:0]            r_wstrb;

    logic w_aw_hs, w_w_hs, w_aw_ok, w_w_ok, w_ar_hs, w_unused;

    assign w_aw_hs = s_axi_awvalid && r_awready;
    assign w_w_hs  = s_axi_wvalid && r_wready;
    assign w_aw_ok = r_aw_got || w_aw_hs;
    assign w_w_ok  = r_w_got || w_w_hs;
    assign w_ar_hs = s_axi_arvalid && r_arready;

`ifdef AXI_GP_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] r_wcnt, r_rcnt;
    assign w_unused = ^{s_axi_awprot, s_axi_arprot,
                        s_axi_awaddr[LSB-1:0], s_axi_araddr[LSB-1:0]};
`else
    assign w_unused = ^{s_axi_awprot, s_axi_arprot,
                        s_axi_awaddr[LSB-1:0], s_axi_araddr[LSB-1:0],
                        (TIMEOUT_CYCLES > 1)};
`endif

    // Write path: AW and W are latched independently, GP access starts once both are held
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_wst     <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_aw_got  <= 1'b0;
            r_w_got   <= 1'b0;
            r_write   <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
`ifdef AXI_GP_TIMEOUT_EN
            r_wcnt    <= '0;
`endif
        end else begin
            unique case (r_wst)
                W_IDLE: begin
                    if (w_aw_hs) r_waddr <= s_axi_awaddr[LSB +: GP_ADDR_WIDTH];
                    if (w_w_hs) begin
                        r_wdata <= s_axi_wdata;
                        r_wstrb <= s_axi_wstrb;
                    end
                    if (w_aw_ok && w_w_ok) begin
                        r_wst     <= W_GP;
                        r_write   <= 1'b1;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_aw_got  <= 1'b0;
                        r_w_got   <= 1'b0;
                    end else begin
                        r_aw_got  <= w_aw_ok;
                        r_w_got   <= w_w_ok;
                        r_awready <= !w_aw_ok;
                        r_wready  <= !w_w_ok;
                    end
                end
                W_GP: begin
                    if (write_done) begin
                        r_write  <= 1'b0;
                        r_bvalid <= 1'b1;
                        r_bresp  <= write_error ? 2'b10 : 2'b00;
                        r_wst    <= W_RESP;
`ifdef AXI_GP_TIMEOUT_EN
                        r_wcnt   <= '0;
                    end else if (r_wcnt == C_LAST) begin
                        r_write  <= 1'b0;
                        r_bvalid <= 1'b1;
                        r_bresp  <= 2'b10;
                        r_wst    <= W_RESP;
                        r_wcnt   <= '0;
                    end else begin
                        r_wcnt   <= r_wcnt + CW'(1);
`endif
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wst     <= W_IDLE;
                    end
                end
                default: r_wst <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_rst     <= R_IDLE;
            r_arready <= 1'b0;
            r_read    <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= 2'b00;
            r_raddr   <= '0;
            r_rdata   <= '0;
`ifdef AXI_GP_TIMEOUT_EN
            r_rcnt    <= '0;
`endif
        end else begin
            unique case (r_rst)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_raddr   <= s_axi_araddr[LSB +: GP_ADDR_WIDTH];
                        r_read    <= 1'b1;
                        r_arready <= 1'b0;
                        r_rst     <= R_GP;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_GP: begin
                    if (read_done) begin
                        r_rdata  <= read_data;
                        r_rresp  <= read_error ? 2'b10 : 2'b00;
                        r_rvalid <= 1'b1;
                        r_read   <= 1'b0;
                        r_rst    <= R_RESP;
`ifdef AXI_GP_TIMEOUT_EN
                        r_rcnt   <= '0;
                    end else if (r_rcnt == C_LAST) begin
                        r_rdata  <= '0;
                        r_rresp  <= 2'b10;
                        r_rvalid <= 1'b1;
                        r_read   <= 1'b0;
                        r_rst    <= R_RESP;
                        r_rcnt   <= '0;
                    end else begin
                        r_rcnt   <= r_rcnt + CW'(1);
`endif
                    end
                end
                R_RESP: begin
                    if (s_axi_rready) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rst     <= R_IDLE;
                    end
                end
                default: r_rst <= R_IDLE;
            endcase
        end
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rdata   = r_rdata;
    assign write         = r_write;
    assign write_addrs   = r_waddr;
    assign write_data    = r_wdata;
    assign write_strobe  = r_wstrb;
    assign read          = r_read;
    assign read_addrs    = r_raddr;

endmodule

// File: tb/tb_axi_lite_gp_bridge.sv
// Bench for axi_lite_gp_bridge: directed table, corner sequences, random concurrent traffic.
// Builds with or without AXI_GP_TIMEOUT_EN; expectations follow the macro.
module tb_axi_lite_gp_bridge;
    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready;
    logic [31:0] wdata, rdata, write_data, read_data;
    logic [3:0]  wstrb, write_strobe;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, arvalid, arready, rvalid, rready;
    logic        write, write_done, write_error;
    logic        read, read_done, read_error;
    logic [5:0]  write_addrs, read_addrs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_lite_gp_bridge #(.TIMEOUT_CYCLES(T)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .s_axi_awaddr(awaddr), .s_axi_awprot(awprot),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(arprot),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .write(write), .write_addrs(write_addrs),
        .write_data(write_data), .write_strobe(write_strobe),
        .write_done(write_done), .write_error(write_error),
        .read(read), .read_addrs(read_addrs), .read_data(read_data),
        .read_done(read_done), .read_error(read_error)
    );

    // Reference model: GP request length and timeout outcome for a done delay
    function automatic int gp_cycles(input int dd);
`ifdef AXI_GP_TIMEOUT_EN
        return (dd + 1 > T) ? T : dd + 1;
`else
        return dd + 1;
`endif
    endfunction

    function automatic bit timed_out(input int dd);
`ifdef AXI_GP_TIMEOUT_EN
        return dd + 1 > T;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int awd, input int wd,
                      input int dd, input bit err, input int bd,
                      input int ehi, input logic [1:0] ebr,
                      input string tag);
        int whigh = 0;
        int bw = 0;
        bit awf = 0, wf = 0, bf = 0;
        bit awdn = 0, wdn = 0, fin = 0, ok = 1;
        logic [1:0] br = 2'b00;
        for (int n = 0; n < 200 && !fin; n++) begin
            if (write) begin
                whigh++;
                if (write_addrs !== a[7:2] || write_data !== d ||
                    write_strobe !== s) ok = 0;
            end
            if (bvalid) begin
                if (bw == 0) br = bresp;
                else if (bresp !== br) ok = 0;
                bw++;
            end
            if (!awdn && n >= awd) begin
                awvalid = 1'b1;
                awaddr = a;
            end else begin
                awaddr = 8'($urandom);
            end
            if (!wdn && n >= wd) begin
                wvalid = 1'b1;
                wdata = d;
                wstrb = s;
            end else begin
                wdata = $urandom;
                wstrb = 4'($urandom);
            end
            awprot = 3'($urandom);
            write_done = write && (whigh > dd);
            write_error = err;
            bready = bvalid && (bw > bd);
            awf = awvalid && awready;
            wf = wvalid && wready;
            bf = bvalid && bready;
            @(posedge clk);
            #1;
            if (awf) begin awvalid = 1'b0; awdn = 1; end
            if (wf) begin wvalid = 1'b0; wdn = 1; end
            if (bf) begin bready = 1'b0; fin = 1; end
        end
        write_done = 1'b0;
        chk({tag, "_wdone"}, 64'(fin), 64'd1);
        chk({tag, "_whigh"}, 64'(whigh), 64'(ehi));
        chk({tag, "_bresp"}, 64'(br), 64'(ebr));
        chk({tag, "_wstable"}, 64'(ok), 64'd1);
        chk({tag, "_widle"}, {61'd0, awready, wready, bvalid}, 64'd6);
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] rv,
                      input int dd, input bit err, input int rrd,
                      input int ehi, input logic [1:0] err_r,
                      input logic [31:0] erd, input string tag);
        int rhigh = 0;
        int rw = 0;
        bit arf = 0, rf = 0, ardn = 0, fin = 0, ok = 1;
        logic [31:0] cap = '0;
        logic [1:0] rr = 2'b00;
        for (int n = 0; n < 200 && !fin; n++) begin
            if (read) begin
                rhigh++;
                if (read_addrs !== a[7:2]) ok = 0;
            end
            if (rvalid) begin
                if (rw == 0) begin cap = rdata; rr = rresp; end
                else if (rdata !== cap || rresp !== rr) ok = 0;
                if (arready !== 1'b0) ok = 0;
                rw++;
            end
            if (!ardn) begin
                arvalid = 1'b1;
                araddr = a;
            end else begin
                araddr = 8'($urandom);
            end
            arprot = 3'($urandom);
            read_done = read && (rhigh > dd);
            read_error = err;
            read_data = read_done ? rv : (rw > 0 ? 32'd0 : $urandom);
            rready = rvalid && (rw > rrd);
            arf = arvalid && arready;
            rf = rvalid && rready;
            @(posedge clk);
            #1;
            if (arf) begin arvalid = 1'b0; ardn = 1; end
            if (rf) begin rready = 1'b0; fin = 1; end
        end
        read_done = 1'b0;
        chk({tag, "_rdone"}, 64'(fin), 64'd1);
        chk({tag, "_rhigh"}, 64'(rhigh), 64'(ehi));
        chk({tag, "_rresp"}, 64'(rr), 64'(err_r));
        chk({tag, "_rdata"}, 64'(cap), 64'(erd));
        chk({tag, "_rstable"}, 64'(ok), 64'd1);
        chk({tag, "_ridle"}, {62'd0, arready, rvalid}, 64'd2);
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        int          awd;
        int          wd;
        int          dd;
        bit          werr;
        int          bd;
        logic [31:0] rv;
        int          rdd;
        bit          rerr;
        int          rrd;
        int          ehi_w;
        logic [1:0]  ebr;
        int          ehi_r;
        logic [1:0]  err_r;
        logic [31:0] erd;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{8'h14, 32'h12345678, 4'hF, 0, 0, 0, 1'b0, 0,
                   32'hBABA1195, 0, 1'b0, 0, 1, 2'b00, 1, 2'b00, 32'hBABA1195};
        tbl[1] = '{8'h08, 32'hCAFE0001, 4'hF, 0, 2, 2, 1'b0, 1,
                   32'hDEADBEEF, 1, 1'b0, 0, 3, 2'b00, 2, 2'b00, 32'hDEADBEEF};
        tbl[2] = '{8'h30, 32'h0BADF00D, 4'h3, 2, 0, 1, 1'b0, 0,
                   32'hDEADBEEF, 0, 1'b0, 3, 2, 2'b00, 1, 2'b00, 32'hDEADBEEF};
        tbl[3] = '{8'h44, 32'h55AA55AA, 4'hF, 1, 1, 0, 1'b1, 0,
                   32'h01020304, 0, 1'b1, 1, 1, 2'b10, 1, 2'b10, 32'h01020304};
        tbl[4] = '{8'hFC, 32'hFFFF0000, 4'h5, 3, 1, 5, 1'b0, 2,
                   32'h87654321, 4, 1'b0, 2, 6, 2'b00, 5, 2'b00, 32'h87654321};

        rst_n = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0;
        wvalid = 0; bready = 0; araddr = '0; arprot = '0; arvalid = 0;
        rready = 0; write_done = 0; write_error = 0; read_data = '0;
        read_done = 0; read_error = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {62'd0, write, read}, 64'd0);
        chk("rst_valid", {62'd0, bvalid, rvalid}, 64'd0);
        chk("rst_resp", {60'd0, bresp, rresp}, 64'd0);
        chk("rst_wout", {write_addrs, write_data, write_strobe}, 64'd0);
        chk("rst_rout", {read_addrs, rdata}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_ready", {61'd0, awready, wready, arready}, 64'd7);

        for (int i = 0; i < 5; i++) begin
            fork
                wr(tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].awd, tbl[i].wd,
                   tbl[i].dd, tbl[i].werr, tbl[i].bd, tbl[i].ehi_w,
                   tbl[i].ebr, $sformatf("tbl%0d", i));
                rd(tbl[i].a ^ 8'h5C, tbl[i].rv, tbl[i].rdd, tbl[i].rerr,
                   tbl[i].rrd, tbl[i].ehi_r, tbl[i].err_r, tbl[i].erd,
                   $sformatf("tbl%0d", i));
            join
        end

        // Long GP wait: times out only when the limit is built in
        rd(8'h24, 32'h13572468, 20, 1'b0, 1, gp_cycles(20),
           timed_out(20) ? 2'b10 : 2'b00,
           timed_out(20) ? 32'd0 : 32'h13572468, "long_rd");
        wr(8'h2C, 32'h24681357, 4'hF, 0, 0, 20, 1'b0, 0, gp_cycles(20),
           timed_out(20) ? 2'b10 : 2'b00, "long_wr");
        // Done exactly at the limit cycle completes as done
        rd(8'h04, 32'h0F0F0F0F, T - 1, 1'b0, 0, T, 2'b00,
           32'h0F0F0F0F, "edge_rd");

        // Reset while the write is waiting on the GP side
        awaddr = 8'h20; awvalid = 1'b1; wdata = 32'hA5A5A5A5;
        wstrb = 4'hF; wvalid = 1'b1; write_done = 1'b0;
        @(posedge clk);
        #1;
        awvalid = 1'b0; wvalid = 1'b0;
        chk("mid_enter", 64'(write), 64'd1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst", {61'd0, write, bvalid, write_data[0]}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_ready", {61'd0, awready, wready, arready}, 64'd7);
        wr(8'h18, 32'h76543210, 4'h9, 0, 0, 1, 1'b0, 0, 2, 2'b00, "post_rst");

        for (int i = 0; i < 24; i++) begin
            logic [7:0] a, b;
            logic [31:0] d, rv;
            logic [3:0] s;
            int wdd, rdd;
            bit we, re;
            a = 8'($urandom); b = 8'($urandom);
            d = $urandom; rv = $urandom; s = 4'($urandom);
            wdd = $urandom_range(0, 20); rdd = $urandom_range(0, 20);
            we = 1'($urandom); re = 1'($urandom);
            fork
                wr(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), wdd,
                   we, $urandom_range(0, 3), gp_cycles(wdd),
                   (timed_out(wdd) || we) ? 2'b10 : 2'b00,
                   $sformatf("rnd%0d", i));
                rd(b, rv, rdd, re, $urandom_range(0, 3), gp_cycles(rdd),
                   (timed_out(rdd) || re) ? 2'b10 : 2'b00,
                   timed_out(rdd) ? 32'd0 : rv, $sformatf("rnd%0d", i));
            join
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
